// File: rtl/debouncer_multi_if.sv
// Raw-input / debounced-output bundle for debouncer_multi.
// Latency: none (wires only).
// Backpressure: none; the outputs are free-running levels and one-cycle ticks.
interface debouncer_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 22
);
    logic [CHANNELS-1:0] i_signal;
    logic [CNT_W-1:0]    i_period;
    logic [CHANNELS-1:0] o_db_level;
    logic [CHANNELS-1:0] o_rise_tick;
    logic [CHANNELS-1:0] o_fall_tick;
    logic                o_any_tick;

    modport master (
        output i_signal,
        output i_period,
        input  o_db_level,
        input  o_rise_tick,
        input  o_fall_tick,
        input  o_any_tick
    );

    modport slave (
        input  i_signal,
        input  i_period,
        output o_db_level,
        output o_rise_tick,
        output o_fall_tick,
        output o_any_tick
    );
endinterface

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: a level must hold for i_period clocks before it is accepted.
// Latency: P+2 clocks from the first sample to the level change, plus 2 with DEBOUNCER_MULTI_SYNC_EN.
// Backpressure: none; ticks are single-cycle pulses that must be consumed when they appear.
module debouncer_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 22
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    debouncer_multi_if.slave  bus
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;

`ifdef DEBOUNCER_MULTI_SYNC_EN
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.i_signal;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = bus.i_signal;
`endif

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
                state_q <= ZERO;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // i_period is only looked at on load, so mid-count changes are ignored.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ZERO: begin
                    if (s[n]) begin
                        state_d = WAIT1;
                        cnt_d   = bus.i_period;
                    end
                end
                WAIT1: begin
                    if (!s[n])              state_d = ZERO;
                    else if (cnt_q != '0)   cnt_d   = cnt_q - CNT_ONE;
                    else                    state_d = ONE;
                end
                ONE: begin
                    if (!s[n]) begin
                        state_d = WAIT0;
                        cnt_d   = bus.i_period;
                    end
                end
                WAIT0: begin
                    if (s[n])               state_d = ONE;
                    else if (cnt_q != '0)   cnt_d   = cnt_q - CNT_ONE;
                    else                    state_d = ZERO;
                end
                default: begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end
            endcase
        end

        assign level_d[n] = (state_q == ONE) || (state_q == WAIT0);
    end

    // Ticks come from the level register's own edge, so reset (which clears it) never yields a fall tick.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign bus.o_db_level  = level_q;
    assign bus.o_rise_tick = rise_q;
    assign bus.o_fall_tick = fall_q;
    assign bus.o_any_tick  = |{rise_q, fall_q};
endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent debounce channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 22, width of each channel's debounce counter and of i_period.
REQ-003 SHALL have port i_clk  input  1  clock, all state updated on rising edge.
REQ-004 SHALL have port i_nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_signal  input  CHANNELS  raw bouncy inputs, bit n drives channel n.
REQ-006 SHALL have port i_period  input  CNT_W  debounce period P in clocks, shared by all channels.
REQ-007 SHALL have port o_db_level  output  CHANNELS  debounced level per channel.
REQ-008 SHALL have port o_rise_tick  output  CHANNELS  one-cycle pulse when a channel's level goes 0->1.
REQ-009 SHALL have port o_fall_tick  output  CHANNELS  one-cycle pulse when a channel's level goes 1->0.
REQ-010 SHALL have port o_any_tick  output  1  OR of all bits of o_rise_tick and o_fall_tick.

Function
REQ-011 SHALL run, per channel, one FSM with states ZERO, WAIT1, ONE, WAIT0 and one CNT_W-bit down-counter; channels share no state.
REQ-012 ZERO: sampled input s=1 -> WAIT1, counter loaded with i_period; s=0 -> stay.
REQ-013 WAIT1: s=0 -> ZERO (bounce rejected, no tick); s=1 and counter!=0 -> decrement, stay; s=1 and counter==0 -> ONE.
REQ-014 ONE: s=0 -> WAIT0, counter loaded with i_period; s=1 -> stay.
REQ-015 WAIT0: s=1 -> ONE (glitch rejected, no tick); s=0 and counter!=0 -> decrement, stay; s=0 and counter==0 -> ZERO.
REQ-016 o_db_level[n] SHALL be registered and equal 1 exactly while channel n is in ONE or WAIT0.
REQ-017 o_rise_tick[n] SHALL be registered, high for exactly the one cycle after the WAIT1->ONE edge; o_fall_tick[n] likewise for WAIT0->ZERO.
REQ-018 With s stable high from the first edge that samples it in ZERO, o_db_level SHALL rise exactly P+2 rising edges later (P=0 gives 2); falling path symmetric.
REQ-019 i_period SHALL be captured only at counter load; changes during WAIT1/WAIT0 SHALL NOT affect the running count.
REQ-020 Counter SHALL never decrement below 0 (no wrap); P = 2^CNT_W-1 SHALL be supported without overflow.
REQ-021 o_any_tick SHALL be combinational OR of the registered tick vectors, same cycle as the ticks.
REQ-022 Simultaneous transitions on several channels SHALL each produce their own ticks in the same cycle.

Reset
REQ-023 While i_nrst=0, every channel SHALL be in ZERO with counter 0; o_db_level, o_rise_tick, o_fall_tick, o_any_tick SHALL be 0, asynchronously.
REQ-024 Reset asserted mid-WAIT1/ONE/WAIT0 SHALL force ZERO with no fall tick generated; after release, a still-high input SHALL require the full P+2 qualification.
REQ-025 Synchroniser flops (if present) SHALL reset to 0.

Configuration
REQ-026 Macro DEBOUNCER_MULTI_SYNC_EN defined: each i_signal bit SHALL pass through a 2-flop synchroniser before the FSM, adding exactly 2 cycles to all latencies in REQ-018.
REQ-027 Macro DEBOUNCER_MULTI_SYNC_EN undefined: FSM SHALL sample i_signal directly; input is then required synchronous to i_clk.

Verification (macro undefined unless noted; CHANNELS=4, CNT_W=8)
REQ-028 P=3, i_signal[0] 0->1 held -> o_db_level[0]=1 and o_rise_tick[0] single pulse 5 edges after first high sample; o_any_tick=1 same cycle.
REQ-029 P=3, i_signal[1] high 3 cycles then low -> returns to ZERO, o_db_level[1] and o_rise_tick[1] stay 0.
REQ-030 Channel 2 debounced high, P=3, 2-cycle low glitch -> o_db_level[2] stays 1, no fall tick; sustained low -> fall tick 5 edges after first low sample.
REQ-031 Channels 0 and 3 rise same cycle, P=0 -> o_rise_tick=4'b1001 for one cycle, 2 edges after sampling.
REQ-032 P=5 load, change i_period to 1 mid-WAIT1 -> rise still after 7 edges; i_nrst pulsed in ONE -> all outputs 0 immediately, no fall tick.
REQ-033 With DEBOUNCER_MULTI_SYNC_EN, P=3 rise -> o_db_level high 7 edges after input change.
